// File: rtl/nand_seq_pkg.sv
// Shared types and helpers for the NAND vector sequencer.
// The state encoding, vector count and expected-value function live here.
package nand_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned NUM_VEC  = 4;
    localparam logic [1:0]  LAST_VEC = 2'(NUM_VEC - 1);

    function automatic logic nand_exp(input logic a, input logic b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/nand_vector_sequencer_hold_timer.sv
// Per-vector hold timer: counts HOLD_CYCLES clocks while run is high and
// flags the terminal count so the top can sample and advance on that edge.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] hold_cnt;

    assign expire = run && (hold_cnt == TERM);

    // Wraps to zero on expiry so the next vector starts a fresh hold window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (clear) begin
            hold_cnt <= '0;
        end else if (run) begin
            if (expire) hold_cnt <= '0;
            else        hold_cnt <= hold_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nand_vector_sequencer.sv
// Drives the NAND cell through its truth table, samples f after a hold time
// and accumulates a saturating error count and a per-vector fail map.
module nand_vector_sequencer
    import nand_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter int unsigned ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             f,
    output logic             a,
    output logic             b,
    output logic [1:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_map
);

    state_t state;
    state_t next_state;
    logic   expire;
    logic   launch;
    logic   sample;

    // abort outranks both a new start and a pending sample on the same edge.
    assign launch = !abort && start && (state != DRIVE);
    assign sample = !abort && (state == DRIVE) && expire;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (launch || abort),
        .run    (state == DRIVE),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = DRIVE;
                DRIVE:   if (expire && (vec_idx == LAST_VEC)) next_state = DONE;
                DONE:    if (start) next_state = DRIVE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state)
            DRIVE: busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (err_count == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx   <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            err_count <= '0;
            fail_map  <= '0;
        end else if (abort) begin
            vec_idx <= '0;
            a       <= 1'b0;
            b       <= 1'b0;
        end else if (launch) begin
            vec_idx   <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            err_count <= '0;
            fail_map  <= '0;
        end else if (sample) begin
            // x/z on f counts as a mismatch in simulation.
            if (f !== nand_exp(a, b)) begin
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
                fail_map[vec_idx] <= 1'b1;
            end
            if (vec_idx != LAST_VEC) begin
                vec_idx  <= vec_idx + 2'd1;
                {a, b}   <= vec_idx + 2'd1;
            end
        end
    end

endmodule
